// File: rtl/alu_acc_sequencer.sv
// Operation sequencer and accumulator wrapped around an external 8-bit ALU.
// Multi-bit shifts are issued as repeated 1-bit ALU shifts, one per EXEC cycle.
module alu_acc_sequencer #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [SEL_W-1:0]   op_code,
  input  logic [DATA_W-1:0]  op_operand,
  input  logic [SHAMT_W-1:0] op_shamt,
  output logic [SEL_W-1:0]   alu_select,
  output logic [DATA_W-1:0]  alu_a_in,
  output logic [DATA_W-1:0]  alu_b_in,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero_flag,
  input  logic               alu_carry_out,
  output logic [DATA_W-1:0]  acc,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               busy,
  output logic               done,
  output logic               op_err
);

  localparam logic [SEL_W-1:0] OP_NOP  = SEL_W'(4'b0000);
  localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(4'b0001);
  localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(4'b0010);
  localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(4'b0011);
  localparam logic [SEL_W-1:0] OP_LDA  = SEL_W'(4'b0100);
  localparam logic [SEL_W-1:0] OP_SHFR = SEL_W'(4'b1011);
  localparam logic [SEL_W-1:0] OP_SHFL = SEL_W'(4'b1100);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state;
  logic [SEL_W-1:0]    op_reg;
  logic [DATA_W-1:0]   operand_reg;
  logic [SHAMT_W-1:0]  cnt;

  assign op_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign alu_a_in = acc;
  assign alu_b_in = operand_reg;

  // The ALU holds its outputs on unhandled selects, so it only sees a real
  // opcode while EXEC is actually sampling it; LDA bypasses the ALU.
  always_comb begin
    alu_select = OP_NOP;
    if (state == EXEC && op_reg != OP_LDA) alu_select = op_reg;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; done/op_err default low and are set only entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_reg      <= OP_NOP;
      operand_reg <= '0;
      cnt         <= '0;
      acc         <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
      done        <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      done   <= 1'b0;
      op_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            op_reg      <= op_code;
            operand_reg <= op_operand;
            case (op_code)
              OP_ADD, OP_SUB, OP_NOR, OP_LDA: begin
                cnt   <= SHAMT_W'(1);
                state <= EXEC;
              end
              OP_SHFL, OP_SHFR: begin
                cnt <= op_shamt;
                if (op_shamt != '0) begin
                  state <= EXEC;
                end else begin
                  state <= DONE;
                  done  <= 1'b1;
                end
              end
              OP_NOP: begin
                state <= DONE;
                done  <= 1'b1;
              end
              default: begin
                state  <= DONE;
                done   <= 1'b1;
                op_err <= 1'b1;
              end
            endcase
          end
        end
        EXEC: begin
          if (op_reg == OP_LDA) begin
            acc        <= operand_reg;
            zero_flag  <= (operand_reg == '0);
            carry_flag <= 1'b0;
          end else begin
            acc        <= alu_out;
            zero_flag  <= alu_zero_flag;
            carry_flag <= alu_carry_out;
          end
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench for alu_acc_sequencer: behavioural ALU model, expected results
// queued at issue time and compared when done is observed.
module tb_alu_acc_sequencer;

  localparam logic [3:0] NOP  = 4'b0000;
  localparam logic [3:0] ADD  = 4'b0001;
  localparam logic [3:0] SUB  = 4'b0010;
  localparam logic [3:0] NOR  = 4'b0011;
  localparam logic [3:0] LDA  = 4'b0100;
  localparam logic [3:0] SHFR = 4'b1011;
  localparam logic [3:0] SHFL = 4'b1100;
  localparam logic [3:0] BAD  = 4'b0101;

  logic       clk, rst, op_valid, op_ready;
  logic [3:0] op_code, alu_select;
  logic [7:0] op_operand, alu_a_in, alu_b_in, alu_out, acc;
  logic [2:0] op_shamt;
  logic       alu_zero_flag, alu_carry_out, zero_flag, carry_flag, busy, done, op_err;

  typedef struct {
    string      tag;
    logic [7:0] acc;
    logic       zero;
    logic       carry;
    logic       err;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  alu_acc_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_operand(op_operand), .op_shamt(op_shamt),
    .alu_select(alu_select), .alu_a_in(alu_a_in), .alu_b_in(alu_b_in),
    .alu_out(alu_out), .alu_zero_flag(alu_zero_flag), .alu_carry_out(alu_carry_out),
    .acc(acc), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .busy(busy), .done(done), .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model; unhandled selects give deliberately odd values so any sampling
  // outside EXEC shows up as corrupted acc/flags.
  always_comb begin
    logic [8:0] wide;
    wide          = '0;
    alu_out       = 8'hA5;
    alu_carry_out = 1'b1;
    alu_zero_flag = 1'b1;
    case (alu_select)
      ADD:  wide = {1'b0, alu_a_in} + {1'b0, alu_b_in};
      SUB:  wide = {1'b0, alu_a_in} - {1'b0, alu_b_in};
      NOR:  wide = {1'b0, ~(alu_a_in | alu_b_in)};
      SHFL: wide = {alu_a_in[7], alu_a_in[6:0], 1'b0};
      SHFR: wide = {alu_a_in[0], 1'b0, alu_a_in[7:1]};
      default: wide = 9'h1A5;
    endcase
    alu_out       = wide[7:0];
    alu_carry_out = wide[8];
    if (alu_select inside {ADD, SUB, NOR, SHFL, SHFR}) alu_zero_flag = (wide[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] a, input logic z, input logic c,
                      input logic e, input int lat);
    exp_t item;
    item.tag = tag; item.acc = a; item.zero = z; item.carry = c; item.err = e; item.lat = lat;
    exp_q.push_back(item);
  endtask

  // Called at the negedge where done is (expected to be) high.
  task automatic pop_compare(input int cycles);
    exp_t e;
    e = exp_q.pop_front();
    check({e.tag, ".done"},    done, 1'b1);
    check({e.tag, ".latency"}, cycles, e.lat);
    check({e.tag, ".acc"},     acc, e.acc);
    check({e.tag, ".zero"},    zero_flag, e.zero);
    check({e.tag, ".carry"},   carry_flag, e.carry);
    check({e.tag, ".op_err"},  op_err, e.err);
  endtask

  // Issue one op from a negedge, wait for done, compare, and end on the
  // negedge after done with the sequencer back in IDLE.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [7:0] operand,
                        input logic [2:0] shamt, input logic [7:0] e_acc, input logic e_z,
                        input logic e_c, input logic e_err, input int lat, output int sel_cycles);
    int cycles;
    int waits;
    push(tag, e_acc, e_z, e_c, e_err, lat);
    op_valid = 1'b1; op_code = code; op_operand = operand; op_shamt = shamt;
    waits = 0;
    while (!op_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check({tag, ".ready"}, op_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP; op_operand = 8'h00; op_shamt = 3'd0;
    cycles = 1;
    sel_cycles = 0;
    while (!done && cycles < 20) begin
      if (alu_select == code) sel_cycles++;
      @(negedge clk);
      cycles++;
    end
    pop_compare(cycles);
    @(negedge clk);
    check({tag, ".pulse"}, {done, op_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int seen;
    rst = 1'b1; op_valid = 1'b0; op_code = NOP; op_operand = 8'h00; op_shamt = 3'd0;
    repeat (2) @(negedge clk);
    check("reset.ready", op_ready, 1'b0);
    check("reset.state", {busy, done, op_err}, 3'b000);
    check("reset.acc",   acc, 8'h00);
    check("reset.flags", {zero_flag, carry_flag}, 2'b00);
    check("reset.sel",   alu_select, NOP);
    rst = 1'b0;
    #1;
    check("reset.ready_after", op_ready, 1'b1);

    // Load, add with carry out, subtract to zero
    run_op("lda7f",  LDA, 8'h7F, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 2, sel);
    run_op("ldaf0",  LDA, 8'hF0, 3'd0, 8'hF0, 1'b0, 1'b0, 1'b0, 2, sel);
    run_op("add20",  ADD, 8'h20, 3'd0, 8'h10, 1'b0, 1'b1, 1'b0, 2, sel);
    run_op("sub10",  SUB, 8'h10, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2, sel);
    run_op("lda0f",  LDA, 8'h0F, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 2, sel);
    run_op("norf0",  NOR, 8'hF0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2, sel);
    check("nor.sel_cycles", sel, 1);
    run_op("lda81",  LDA, 8'h81, 3'd0, 8'h81, 1'b0, 1'b0, 1'b0, 2, sel);

    // Shift left by 3 while a new op is held on op_valid
    push("shfl3", 8'h08, 1'b0, 1'b0, 1'b0, 4);
    op_valid = 1'b1; op_code = SHFL; op_operand = 8'h00; op_shamt = 3'd3;
    check("shfl3.ready", op_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    op_code = ADD; op_operand = 8'hF9; op_shamt = 3'd0;
    check("shfl3.exec1", {busy, op_ready, acc}, {2'b10, 8'h81});
    check("shfl3.sel",   alu_select, SHFL);
    @(negedge clk);
    check("shfl3.exec2", {op_ready, acc}, {1'b0, 8'h02});
    @(negedge clk);
    check("shfl3.exec3", {op_ready, acc}, {1'b0, 8'h04});
    @(negedge clk);
    check("shfl3.hold_ready", op_ready, 1'b0);
    pop_compare(4);
    // The held ADD is taken only once the sequencer is back in IDLE
    run_op("addf9",  ADD, 8'hF9, 3'd0, 8'h01, 1'b0, 1'b1, 1'b0, 2, sel);

    // Zero-length shift, NOP and an unsupported opcode leave acc/flags alone
    run_op("shfr0",  SHFR, 8'h00, 3'd0, 8'h01, 1'b0, 1'b1, 1'b0, 1, sel);
    run_op("nop",    NOP,  8'h33, 3'd5, 8'h01, 1'b0, 1'b1, 1'b0, 1, sel);
    run_op("bad",    BAD,  8'h33, 3'd0, 8'h01, 1'b0, 1'b1, 1'b1, 1, sel);

    // Reset in the third EXEC cycle of a 7-step right shift aborts silently
    run_op("ldaff",  LDA, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 2, sel);
    op_valid = 1'b1; op_code = SHFR; op_shamt = 3'd7;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op_code = NOP; op_shamt = 3'd0;
    check("abort.exec1", acc, 8'hFF);
    @(negedge clk);
    check("abort.exec2", {acc, carry_flag}, {8'h7F, 1'b1});
    @(negedge clk);
    check("abort.exec3", acc, 8'h3F);
    rst = 1'b1;
    #1;
    check("abort.ready_in_rst", op_ready, 1'b0);
    @(negedge clk);
    check("abort.state", {busy, done, op_err}, 3'b000);
    check("abort.acc",   acc, 8'h00);
    check("abort.flags", {zero_flag, carry_flag}, 2'b00);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort.no_done", seen, 0);
    run_op("lda00",  LDA, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 2, sel);
    check("queue.empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
